// File: rtl/wf_done_queue_if.sv
// Done-ID handshake: retire producers and allocator stall on one side, the queue on the other.
// The bench (or upstream wrapper) uses master; wf_done_queue uses slave.
interface wf_done_queue_if #(
   parameter int unsigned WFID_W = 6
);
   logic              src0_done;
   logic [WFID_W-1:0] src0_wfid;
   logic              src1_done;
   logic [WFID_W-1:0] src1_wfid;
   logic              src_ready;
   logic              dn_stall;
   logic [WFID_W-1:0] WF_id_done;
   logic              WF_done_valid;

   modport master (
      output src0_done, src0_wfid, src1_done, src1_wfid, dn_stall,
      input  src_ready, WF_id_done, WF_done_valid
   );

   modport slave (
      input  src0_done, src0_wfid, src1_done, src1_wfid, dn_stall,
      output src_ready, WF_id_done, WF_done_valid
   );
endinterface

// File: rtl/wf_done_queue.sv
// In-order queue of wavefront-done IDs from two retire paths, released one per cycle.
// Optional duplicate filtering via a pending bitmap when WF_DONE_DUP_CHECK_EN is defined.
module wf_done_queue #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned WFID_W = 6,
   parameter int unsigned NUM_WF = 40
) (
   input  logic                   clk,
   input  logic                   rst,
   wf_done_queue_if.slave         q,
   output logic [$clog2(DEPTH):0] occupancy,
   output logic                   err_overflow,
   output logic                   err_bad_id
`ifdef WF_DONE_DUP_CHECK_EN
   ,
   output logic                   err_dup_id
`endif
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WFID_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0]     cnt_q, cnt_d, free;
   logic              valid_q, valid_d;
   logic [WFID_W-1:0] id_q, id_d, head_d;
   logic              ovf_q, ovf_d, bad_q, bad_d;
   logic              pop, in0, in1, ok0, ok1, acc0, acc1;

`ifdef WF_DONE_DUP_CHECK_EN
   logic [NUM_WF-1:0] pend_q, pend_d, live;
   logic              dup0, dup1, dup_q, dup_d;
`endif

   always_comb begin
      // The registered output is the release itself; it is consumed at the next edge.
      pop = valid_q;
      in0 = 32'(q.src0_wfid) < NUM_WF;
      in1 = 32'(q.src1_wfid) < NUM_WF;
      bad_d = (q.src0_done && !in0) || (q.src1_done && !in1);
      ok0 = q.src0_done && in0;
      ok1 = q.src1_done && in1;
      free = CW'(DEPTH) - cnt_q + CW'(pop);
`ifdef WF_DONE_DUP_CHECK_EN
      live = pend_q;
      if (pop) live[id_q] = 1'b0;
      dup0 = ok0 && live[q.src0_wfid];
      ok0  = ok0 && !dup0;
`endif
      acc0 = ok0 && (free != '0);
`ifdef WF_DONE_DUP_CHECK_EN
      dup1  = ok1 && (live[q.src1_wfid] || (acc0 && (q.src0_wfid == q.src1_wfid)));
      ok1   = ok1 && !dup1;
      dup_d = dup0 || dup1;
`endif
      acc1  = ok1 && (free > CW'(acc0));
      ovf_d = ovf_q || (ok0 && !acc0) || (ok1 && !acc1);
      cnt_d = cnt_q + CW'(acc0) + CW'(acc1) - CW'(pop);
      rd_d  = rd_q + PW'(pop);
      wr_d  = wr_q + PW'(acc0) + PW'(acc1);
      // With nothing left behind the release, the new head is this cycle's first push.
      if ((cnt_q - CW'(pop)) != '0) begin
         head_d = mem_q[rd_d];
      end else if (acc0) begin
         head_d = q.src0_wfid;
      end else begin
         head_d = q.src1_wfid;
      end
      valid_d = !q.dn_stall && (cnt_d != '0);
      id_d    = valid_d ? head_d : id_q;
`ifdef WF_DONE_DUP_CHECK_EN
      pend_d = live;
      if (acc0) pend_d[q.src0_wfid] = 1'b1;
      if (acc1) pend_d[q.src1_wfid] = 1'b1;
`endif
   end

   always_ff @(posedge clk) begin
      if (acc0) mem_q[wr_q] <= q.src0_wfid;
      if (acc1) mem_q[wr_q + PW'(acc0)] <= q.src1_wfid;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q    <= '0;
         wr_q    <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         id_q    <= '0;
         ovf_q   <= 1'b0;
         bad_q   <= 1'b0;
      end else begin
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         id_q    <= id_d;
         ovf_q   <= ovf_d;
         bad_q   <= bad_d;
      end
   end

`ifdef WF_DONE_DUP_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q <= '0;
         dup_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         dup_q  <= dup_d;
      end
   end

   assign err_dup_id = dup_q;
`endif

   assign q.WF_done_valid = valid_q;
   assign q.WF_id_done    = id_q;
   assign q.src_ready     = (CW'(DEPTH) - cnt_q) >= CW'(2);
   assign occupancy       = cnt_q;
   assign err_overflow    = ovf_q;
   assign err_bad_id      = bad_q;
endmodule
